mips_mem_arbiter: RTL



---
 rtl/mips_mem_arbiter_pkg.sv | 21 ++
 rtl/mips_mem_arbiter_if.sv | 62 ++++++
 rtl/mips_mem_arbiter_rr_starve_ctr.sv | 25 ++
 rtl/mips_mem_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mips_mem_arbiter_pkg.sv
// mips32_pkg: shared types for the MIPS32 unified-memory arbiter.
// Holds the FSM state encoding, requester IDs and width defaults.
package mips32_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DEBUG = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        ID_NONE = 2'd0,
        ID_IF   = 2'd1,
        ID_D    = 2'd2,
        ID_DBG  = 2'd3
    } req_id_t;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if: requester and memory-port bundle of the arbiter.
// master = pipeline/memory side, slave = arbiter side.
interface mips_mem_arbiter_if
    import mips32_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;

    logic              stall_if;
    logic              stall_mem;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid,
        input  stall_if, stall_mem,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid,
        output stall_if, stall_mem,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/mips_mem_arbiter_rr_starve_ctr.sv
// mips_rr_starve_ctr: counts consecutive denied fetch cycles, saturating.
// Ports: clk, rst_n, clr, inc in; promote out (count reached MAX_WAIT).
module mips_rr_starve_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic promote
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc && !promote) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign promote = (cnt == 4'(MAX_WAIT));

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one memory port among IF, MEM and debug.
// Ports: clk, rst_n, cpu_halted; bus (slave) carries requests/grants/mem.
module mips_mem_arbiter
    import mips32_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_halted,
    mips_mem_arbiter_if.slave bus
);

    arb_state_t        state;
    arb_state_t        nstate;
    req_id_t           gid;
    req_id_t           last_id;
    logic              promote;
    logic              rd_gnt;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              ctr_clr;
    logic              ctr_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            RUN:     if (cpu_halted) nstate = DRAIN;
            DRAIN:   nstate = DEBUG;
            DEBUG:   if (!cpu_halted) nstate = RUN;
            default: nstate = RUN;
        endcase
    end

    // Grant decode: a halt seen this cycle still arbitrates under RUN.
    always_comb begin
        gid = ID_NONE;
        if (rst_n) begin
            unique case (state)
                RUN: begin
                    if (bus.if_req && (promote || !bus.d_req)) begin
                        gid = ID_IF;
                    end else if (bus.d_req) begin
                        gid = ID_D;
                    end
                end
                DEBUG: begin
                    if (bus.dbg_req) gid = ID_DBG;
                end
                default: gid = ID_NONE;
            endcase
        end
    end

    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        unique case (gid)
            ID_IF: begin
                addr_sel = bus.if_addr;
            end
            ID_D: begin
                we_sel    = bus.d_we;
                addr_sel  = bus.d_addr;
                wdata_sel = bus.d_wdata;
            end
            ID_DBG: begin
                we_sel    = bus.dbg_we;
                addr_sel  = bus.dbg_addr;
                wdata_sel = bus.dbg_wdata;
            end
            default: begin
                we_sel = 1'b0;
            end
        endcase
    end

    assign rd_gnt = (gid != ID_NONE) && !we_sel;

    // Remembers who owns the read in flight so rdata can be tagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_id <= ID_NONE;
        end else begin
            last_id <= rd_gnt ? gid : ID_NONE;
        end
    end

    assign bus.if_gnt    = (gid == ID_IF);
    assign bus.d_gnt     = (gid == ID_D);
    assign bus.dbg_gnt   = (gid == ID_DBG);

    // Held low in reset so a read issued just before reset is dropped.
    assign bus.if_rvalid  = rst_n && (last_id == ID_IF);
    assign bus.d_rvalid   = rst_n && (last_id == ID_D);
    assign bus.dbg_rvalid = rst_n && (last_id == ID_DBG);

    assign bus.stall_if  = rst_n && bus.if_req && !bus.if_gnt;
    assign bus.stall_mem = rst_n && bus.d_req && !bus.d_gnt;

    assign bus.mem_en    = (gid != ID_NONE);
    assign bus.mem_we    = we_sel;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;

    // Starvation count only matters in RUN; it restarts on return.
    assign ctr_clr = (state != RUN) || !bus.if_req || bus.if_gnt;
    assign ctr_inc = bus.if_req && !bus.if_gnt;

    mips_rr_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (ctr_clr),
        .inc     (ctr_inc),
        .promote (promote)
    );

endmodule
